// File: rtl/irq_ctrl_6502.sv
// Interrupt controller for the cpu_6502 bus: edge-latched IRQ sources, mask, cause, NMI sync.
// Define IRQCTL_TIMER_EN to build the periodic timer that drives PEND[7].
module irq_ctrl_6502 #(
  parameter logic [15:0] BASE = 16'hD000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ab,
  input  logic [7:0]  dout,
  input  logic        we,
  input  logic        rdy,
  input  logic [6:0]  irq_src,
  input  logic        nmi_src,
  output logic [7:0]  rd_data,
  output logic        rd_sel,
  output logic        irq,
  output logic        nmi
);

  logic [6:0] s1_q, s2_q, s3_q;
  logic [1:0] arm_q;
  logic       nmi1_q, nmi2_q, nmi_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q;
  logic       irq_q;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_sel_q, rd_sel_d;

  logic       hit;
  logic       wr_ok;
  logic [7:0] act;
  logic [7:0] cause;
  logic [2:0] idx;
  logic [7:0] rd_mux;
  logic [7:0] timer_rd;
  logic       tick;
  logic [7:0] clr;
  logic [6:0] rise;

  assign hit   = (ab[15:2] == BASE[15:2]);
  assign wr_ok = rdy & we & hit;
  assign act   = pend_q & mask_q;

`ifdef IRQCTL_TIMER_EN
  logic [7:0] reload_q, cnt_q;
  logic       wr_tmr;

  assign wr_tmr   = wr_ok & (ab[1:0] == 2'd3);
  assign tick     = ~wr_tmr & (reload_q != 8'd0) & (cnt_q == 8'd1);
  assign timer_rd = reload_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= 8'd0;
      cnt_q    <= 8'd0;
    end else if (wr_tmr) begin
      reload_q <= dout;
      cnt_q    <= dout;
    end else if (reload_q != 8'd0) begin
      if (cnt_q == 8'd1) cnt_q <= reload_q;
      else               cnt_q <= cnt_q - 8'd1;
    end
  end
`else
  assign tick     = 1'b0;
  assign timer_rd = 8'd0;
`endif

  // Sources already high when reset lifts look like edges; blank
  // set events until the edge-detect flop holds real history.
  assign rise = s2_q & ~s3_q & {7{arm_q == 2'd3}};
  assign clr  = (wr_ok && ab[1:0] == 2'd0) ? dout : 8'd0;

  always_comb begin
    pend_d = (pend_q & ~clr) | {tick, rise};
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) idx = i[2:0];
    end
    cause = {|act, 4'b0000, idx};
  end

  always_comb begin
    rd_mux = 8'd0;
    case (ab[1:0])
      2'd0: rd_mux = pend_q;
      2'd1: rd_mux = mask_q;
      2'd2: rd_mux = cause;
      2'd3: rd_mux = timer_rd;
      default: rd_mux = 8'd0;
    endcase
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_sel_d  = rd_sel_q;
    if (rdy) begin
      rd_sel_d = hit & ~we;
      if (hit && !we) rd_data_d = rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 7'd0;
      s2_q      <= 7'd0;
      s3_q      <= 7'd0;
      arm_q     <= 2'd0;
      nmi1_q    <= 1'b0;
      nmi2_q    <= 1'b0;
      nmi_q     <= 1'b0;
      pend_q    <= 8'd0;
      mask_q    <= 8'd0;
      irq_q     <= 1'b0;
      rd_data_q <= 8'd0;
      rd_sel_q  <= 1'b0;
    end else begin
      s1_q      <= irq_src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
      nmi1_q    <= nmi_src;
      nmi2_q    <= nmi1_q;
      nmi_q     <= nmi2_q;
      pend_q    <= pend_d;
      if (wr_ok && ab[1:0] == 2'd1) mask_q <= dout;
      irq_q     <= |act;
      rd_data_q <= rd_data_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_sel  = rd_sel_q;
  assign irq     = irq_q;
  assign nmi     = nmi_q;

endmodule
